// File: rtl/uart_rx_cfg_pkg.sv
// Shared UART types: parity selection, receiver FSM states and the 3-sample majority vote.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_e;

    // PARITY_BIT rather than PARITY so the state never collides with the PARITY parameter.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY_BIT,
        STOP,
        BREAK
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Serial line input plus received-word stream with error flags, overrun and busy status.
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic [DATA_BITS-1:0] out_data;
    logic                 out_parity_err;
    logic                 out_frame_err;
    logic                 out_valid;
    logic                 out_ready;
    logic                 overrun;
    logic                 busy;

    modport master (
        input  rx, out_ready,
        output out_data, out_parity_err, out_frame_err, out_valid, overrun, busy
    );

    modport slave (
        output rx, out_ready,
        input  out_data, out_parity_err, out_frame_err, out_valid, overrun, busy
    );
endinterface

// File: rtl/uart_rx_cfg_baud_tick.sv
// Free-running oversample tick generator: one-clock pulse every CLK_DIV clocks.
module uart_baud_tick #(
    parameter int CLK_DIV = 3
) (
    input  logic clk,
    input  logic reset,
    output logic o_tick
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_tick_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == LAST) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    assign o_tick = (r_tick_cnt == LAST);
endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver with majority-voted bit sampling, parity/framing checks, break recovery
// and a valid/ready output register that flags overrun when a finished word cannot be stored.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int      CLK_DIV    = 3,
    parameter int      OVERSAMPLE = 16,
    parameter int      DATA_BITS  = 8,
    parameter parity_e PARITY     = PAR_NONE,
    parameter int      STOP_BITS  = 1
) (
    input logic           clk,
    input logic           reset,
    uart_rx_cfg_if.master bus
);
    localparam int PH_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BC_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0] PH_S0   = PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [PH_W-1:0] PH_S1   = PH_W'(OVERSAMPLE / 2);
    localparam logic [PH_W-1:0] PH_DEC  = PH_W'(OVERSAMPLE / 2 + 1);
    localparam logic [BC_W-1:0] DATA_LAST = BC_W'(DATA_BITS - 1);
    localparam logic [BC_W-1:0] STOP_LAST = BC_W'(STOP_BITS - 1);

    logic                 w_tick;
    logic                 r_rx_meta, r_rxs;
    rx_state_e            r_state;
    logic [PH_W-1:0]      r_ph;
    logic [BC_W-1:0]      r_bit_cnt;
    logic                 r_s0, r_s1;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr, r_ferr;
    logic [DATA_BITS-1:0] r_out_data;
    logic                 r_out_perr, r_out_ferr, r_out_valid, r_overrun;
    logic                 w_dec, w_wrap, w_bit, w_complete, w_ferr_final, w_par_err;

    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk    (clk),
        .reset  (reset),
        .o_tick (w_tick)
    );

    assign w_dec        = w_tick && (r_ph == PH_DEC);
    assign w_wrap       = w_tick && (r_ph == PH_LAST);
    assign w_bit        = majority3(r_s0, r_s1, r_rxs);
    assign w_complete   = w_dec && (r_state == STOP) && (r_bit_cnt == STOP_LAST);
    assign w_ferr_final = r_ferr | ~w_bit;
    assign w_par_err    = ((^r_shift) ^ w_bit) != (PARITY == PAR_ODD);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta   <= 1'b1;
            r_rxs       <= 1'b1;
            r_state     <= IDLE;
            r_ph        <= '0;
            r_bit_cnt   <= '0;
            r_s0        <= 1'b1;
            r_s1        <= 1'b1;
            r_shift     <= '0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_out_data  <= '0;
            r_out_perr  <= 1'b0;
            r_out_ferr  <= 1'b0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_rx_meta <= bus.rx;
            r_rxs     <= r_rx_meta;
            r_overrun <= 1'b0;

            if (w_tick && r_ph == PH_S0) r_s0 <= r_rxs;
            if (w_tick && r_ph == PH_S1) r_s1 <= r_rxs;
            if (w_tick && r_state != IDLE && r_state != BREAK)
                r_ph <= w_wrap ? '0 : r_ph + 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_tick && !r_rxs) begin
                        r_state   <= START;
                        r_ph      <= PH_W'(1);
                        r_bit_cnt <= '0;
                        r_perr    <= 1'b0;
                        r_ferr    <= 1'b0;
                    end
                end
                START: begin
                    if (w_dec && w_bit) begin
                        r_state <= IDLE;
                        r_ph    <= '0;
                    end else if (w_wrap) begin
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_dec) r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                    if (w_wrap) begin
                        if (r_bit_cnt == DATA_LAST) begin
                            r_bit_cnt <= '0;
                            r_state   <= (PARITY == PAR_NONE) ? STOP : PARITY_BIT;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                PARITY_BIT: begin
                    if (w_dec)  r_perr  <= w_par_err;
                    if (w_wrap) r_state <= STOP;
                end
                STOP: begin
                    if (w_dec) r_ferr <= w_ferr_final;
                    // The frame ends at the last stop-bit decision, leaving the rest of the bit to resync.
                    if (w_complete) begin
                        r_state   <= w_ferr_final ? BREAK : IDLE;
                        r_ph      <= '0;
                        r_bit_cnt <= '0;
                    end else if (w_wrap) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (w_tick && r_rxs) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            if (w_complete) begin
                if (!r_out_valid || bus.out_ready) begin
                    r_out_data  <= r_shift;
                    r_out_perr  <= r_perr;
                    r_out_ferr  <= w_ferr_final;
                    r_out_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_data       = r_out_data;
    assign bus.out_parity_err = r_out_perr;
    assign bus.out_frame_err  = r_out_ferr;
    assign bus.out_valid      = r_out_valid;
    assign bus.overrun        = r_overrun;
    assign bus.busy           = (r_state != IDLE);
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three receivers (8N1, 8E1, 8O2) sharing clock and reset.
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int BIT_CLKS = 48;

    logic clk = 1'b0;
    logic reset;
    int   cyc;
    int   n_cmp = 0;
    int   n_fail = 0;

    int         rises, ovr, first_cnt;
    logic [7:0] cap_d;
    logic       cap_pe, cap_fe;

    logic       s_v, s_pe, s_fe, s_ov, s_bz;
    logic [7:0] s_d;

    uart_rx_cfg_if #(.DATA_BITS(8)) if_n ();
    uart_rx_cfg_if #(.DATA_BITS(8)) if_e ();
    uart_rx_cfg_if #(.DATA_BITS(8)) if_o ();

    uart_rx_cfg #(.CLK_DIV(3), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1))
        dut_n (.clk(clk), .reset(reset), .bus(if_n));
    uart_rx_cfg #(.CLK_DIV(3), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1))
        dut_e (.clk(clk), .reset(reset), .bus(if_e));
    uart_rx_cfg #(.CLK_DIV(3), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(2))
        dut_o (.clk(clk), .reset(reset), .bus(if_o));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_rx(input int sel, input logic val);
        case (sel)
            0: if_n.rx = val;
            1: if_e.rx = val;
            default: if_o.rx = val;
        endcase
    endtask

    task automatic drive_rdy(input int sel, input logic val);
        case (sel)
            0: if_n.out_ready = val;
            1: if_e.out_ready = val;
            default: if_o.out_ready = val;
        endcase
    endtask

    task automatic sample(input int sel);
        case (sel)
            0: begin
                s_v = if_n.out_valid; s_d = if_n.out_data; s_pe = if_n.out_parity_err;
                s_fe = if_n.out_frame_err; s_ov = if_n.overrun; s_bz = if_n.busy;
            end
            1: begin
                s_v = if_e.out_valid; s_d = if_e.out_data; s_pe = if_e.out_parity_err;
                s_fe = if_e.out_frame_err; s_ov = if_e.overrun; s_bz = if_e.busy;
            end
            default: begin
                s_v = if_o.out_valid; s_d = if_o.out_data; s_pe = if_o.out_parity_err;
                s_fe = if_o.out_frame_err; s_ov = if_o.overrun; s_bz = if_o.busy;
            end
        endcase
    endtask

    function automatic logic [15:0] f8n1(input logic [7:0] d);
        return {6'b0, 1'b1, d, 1'b0};
    endfunction

    function automatic logic [15:0] fpar(input logic [7:0] d, input logic p,
                                         input logic s1, input logic s2);
        return {4'b0, s2, s1, p, d, 1'b0};
    endfunction

    // Line bits go out LSB first, each BIT_CLKS long, starting on a clock where cyc%3==0.
    // Records valid rises (with captured word), overrun pulses and the first-rise clock count.
    task automatic send_bits(input int sel, input logic [15:0] v, input int n, input int rdy_at);
        logic pv;
        int   cnt;
        while (cyc % 3 != 0) @(negedge clk);
        rises = 0; ovr = 0; first_cnt = -1; cnt = 0;
        cap_d = 8'h0; cap_pe = 1'b0; cap_fe = 1'b0;
        sample(sel);
        pv = s_v;
        for (int b = 0; b < n; b++) begin
            drive_rx(sel, v[b]);
            repeat (BIT_CLKS) begin
                @(negedge clk);
                cnt++;
                if (cnt == rdy_at)          drive_rdy(sel, 1'b1);
                else if (cnt == rdy_at + 1) drive_rdy(sel, 1'b0);
                sample(sel);
                if (s_v && !pv) begin
                    rises++;
                    if (first_cnt < 0) first_cnt = cnt;
                    cap_d = s_d; cap_pe = s_pe; cap_fe = s_fe;
                end
                if (s_ov) ovr++;
                pv = s_v;
            end
        end
        drive_rx(sel, 1'b1);
    endtask

    initial begin
        int glitch_rises;
        reset = 1'b1;
        if_n.rx = 1'b1; if_e.rx = 1'b1; if_o.rx = 1'b1;
        if_n.out_ready = 1'b1; if_e.out_ready = 1'b1; if_o.out_ready = 1'b1;
        repeat (4) @(negedge clk);

        sample(0);
        chk("reset_valid", 32'(s_v), 0);
        chk("reset_busy", 32'(s_bz), 0);
        chk("reset_data", 32'(s_d), 0);
        chk("reset_overrun", 32'(s_ov), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // 8N1 0xA5: start seen on the tick 3 clocks after the edge, stop decided 153 ticks later
        send_bits(0, f8n1(8'hA5), 10, -1);
        chk("a5_rises", 32'(rises), 1);
        chk("a5_data", 32'(cap_d), 'hA5);
        chk("a5_perr", 32'(cap_pe), 0);
        chk("a5_ferr", 32'(cap_fe), 0);
        chk("a5_latency", 32'(first_cnt), 462);

        // 8E1 0x3C carries 4 ones, so even parity bit should be 0; send 1
        send_bits(1, fpar(8'h3C, 1'b1, 1'b1, 1'b1), 11, -1);
        chk("e_data", 32'(cap_d), 'h3C);
        chk("e_perr", 32'(cap_pe), 1);
        chk("e_ferr", 32'(cap_fe), 0);

        // 8O2 0x81 with correct odd parity 1, second stop bit low
        send_bits(2, fpar(8'h81, 1'b1, 1'b1, 1'b0), 12, -1);
        chk("o_data", 32'(cap_d), 'h81);
        chk("o_ferr", 32'(cap_fe), 1);
        chk("o_perr", 32'(cap_pe), 0);
        repeat (20) @(negedge clk);
        send_bits(2, fpar(8'h55, 1'b1, 1'b1, 1'b1), 12, -1);
        chk("o55_rises", 32'(rises), 1);
        chk("o55_data", 32'(cap_d), 'h55);
        chk("o55_ferr", 32'(cap_fe), 0);
        chk("o55_perr", 32'(cap_pe), 0);

        // 15-clock low pulse (5 ticks) is rejected at the start-bit decision
        if_n.rx = 1'b0;
        repeat (15) @(negedge clk);
        sample(0);
        chk("glitch_busy_mid", 32'(s_bz), 1);
        if_n.rx = 1'b1;
        glitch_rises = 0;
        repeat (60) begin
            @(negedge clk);
            sample(0);
            if (s_v) glitch_rises++;
        end
        chk("glitch_no_word", 32'(glitch_rises), 0);
        chk("glitch_busy_end", 32'(s_bz), 0);
        send_bits(0, f8n1(8'h12), 10, -1);
        chk("g12_data", 32'(cap_d), 'h12);
        chk("g12_ferr", 32'(cap_fe), 0);

        // Overrun: hold off the consumer across two frames
        if_n.out_ready = 1'b0;
        send_bits(0, f8n1(8'h11), 10, -1);
        chk("ov11_data", 32'(cap_d), 'h11);
        send_bits(0, f8n1(8'h22), 10, -1);
        sample(0);
        chk("ov22_pulse", 32'(ovr), 1);
        chk("ov22_keep", 32'(s_d), 'h11);
        chk("ov22_valid", 32'(s_v), 1);
        // ready high only during the clock whose edge completes 0x33
        send_bits(0, f8n1(8'h33), 10, 461);
        sample(0);
        chk("ov33_pulse", 32'(ovr), 0);
        chk("ov33_data", 32'(s_d), 'h33);
        chk("ov33_valid", 32'(s_v), 1);
        if_n.out_ready = 1'b1;
        @(negedge clk);
        sample(0);
        chk("accept_clears", 32'(s_v), 0);

        // 14 bit-times of continuous low: one framing-error word only
        send_bits(0, 16'h0000, 14, -1);
        chk("brk_rises", 32'(rises), 1);
        chk("brk_data", 32'(cap_d), 0);
        chk("brk_ferr", 32'(cap_fe), 1);
        repeat (20) @(negedge clk);
        sample(0);
        chk("brk_idle", 32'(s_bz), 0);

        // Reset part-way through 0x77, then a clean 0x77
        send_bits(0, 16'b1110, 4, -1);
        sample(0);
        chk("mid_busy", 32'(s_bz), 1);
        reset = 1'b1;
        if_n.rx = 1'b1;
        repeat (2) @(negedge clk);
        sample(0);
        chk("mid_rst_valid", 32'(s_v), 0);
        chk("mid_rst_busy", 32'(s_bz), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        send_bits(0, f8n1(8'h77), 10, -1);
        chk("r77_rises", 32'(rises), 1);
        chk("r77_data", 32'(cap_d), 'h77);
        chk("r77_ferr", 32'(cap_fe), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
